pcg32_range_sampler: RTL and testbench

- Downstream consumer of the PCG32 generator's 32-bit output words.
- Turns a request for an integer in [0, bound) into an unbiased sample using Lemire multiply-and-reject.
- Rejection threshold t = (2^32 - bound) mod bound is computed once per request by an iterative remainder unit.
- Random words are pulled over a valid/ready port placed in front of the generator; results leave over a valid/ready port.

---
 rtl/pcg32_range_sampler_pkg.sv | 15 +
 rtl/pcg32_mod_unit.sv | 57 +++++
 rtl/pcg32_range_sampler.sv | 109 ++++++++++
 tb/tb_pcg32_range_sampler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcg32_range_sampler_pkg.sv
// Shared types and widths for the PCG32 bounded-range sampler.
package pcg32_range_sampler_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned PROD_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIV,
        ST_FETCH,
        ST_MUL,
        ST_OUT
    } state_t;

endpackage

// File: rtl/pcg32_mod_unit.sv
// Iterative restoring remainder of (2^32 - divisor) mod divisor, one bit per cycle.
module pcg32_mod_unit
    import pcg32_range_sampler_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] divisor,
    output logic              done,
    output logic [WORD_W-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(WORD_W);

    logic              busy;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] dvd;
    logic [WORD_W-1:0] dsr;
    logic [WORD_W-1:0] rem;
    logic [WORD_W-1:0] rem_next;
    logic [WORD_W:0]   trial;
    logic [WORD_W:0]   diff;

    // rem < dsr is invariant, so the restored value always fits in WORD_W bits
    always_comb begin
        trial    = {rem, dvd[WORD_W-1]};
        diff     = trial - {1'b0, dsr};
        rem_next = (trial >= {1'b0, dsr}) ? diff[WORD_W-1:0] : trial[WORD_W-1:0];
    end

    assign done      = busy && (cnt == CNT_W'(WORD_W - 1));
    assign remainder = rem_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
            dvd  <= '0;
            dsr  <= '0;
            rem  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            dvd  <= '0 - divisor;
            dsr  <= divisor;
            rem  <= '0;
        end else if (busy) begin
            rem <= rem_next;
            dvd <= dvd << 1;
            cnt <= cnt + CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pcg32_range_sampler.sv
// Unbiased [0, bound) sampler over PCG32 words using Lemire multiply-and-reject.
module pcg32_range_sampler
    import pcg32_range_sampler_pkg::*;
#(
    parameter int unsigned REJ_CNT_W = 8
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WORD_W-1:0]    req_bound,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    input  logic [WORD_W-1:0]    rnd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_W-1:0]    out_data,
    output logic [REJ_CNT_W-1:0] out_rejects
);

    state_t               state;
    state_t               state_next;
    logic [WORD_W-1:0]    s;
    logic [WORD_W-1:0]    t;
    logic [PROD_W-1:0]    m;
    logic [WORD_W-1:0]    data_q;
    logic [REJ_CNT_W-1:0] rej;
    logic                 reject;
    logic                 div_start;
    logic                 div_done;
    logic [WORD_W-1:0]    div_rem;

    assign req_ready   = (state == ST_IDLE);
    assign rnd_ready   = (state == ST_FETCH);
    assign out_valid   = (state == ST_OUT);
    assign out_data    = data_q;
    assign out_rejects = rej;
    assign div_start   = req_valid && req_ready && (req_bound != '0);
    assign reject      = (m[WORD_W-1:0] < t);

    pcg32_mod_unit u_mod (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .divisor   (req_bound),
        .done      (div_done),
        .remainder (div_rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (req_valid) state_next = (req_bound == '0) ? ST_FETCH : ST_DIV;
            ST_DIV:   if (div_done) state_next = ST_FETCH;
            ST_FETCH: if (rnd_valid) state_next = ST_MUL;
            ST_MUL:   state_next = reject ? ST_FETCH : ST_OUT;
            ST_OUT:   if (out_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // s = 0 forces the low half to all-ones so the full-range word always passes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s      <= '0;
            t      <= '0;
            m      <= '0;
            data_q <= '0;
            rej    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        s   <= req_bound;
                        t   <= '0;
                        rej <= '0;
                    end
                end
                ST_DIV: begin
                    if (div_done) t <= div_rem;
                end
                ST_FETCH: begin
                    if (rnd_valid) begin
                        m <= (s == '0) ? {rnd_data, {WORD_W{1'b1}}}
                                       : {{WORD_W{1'b0}}, rnd_data} * {{WORD_W{1'b0}}, s};
                    end
                end
                ST_MUL: begin
                    if (reject) begin
                        if (rej != '1) rej <= rej + REJ_CNT_W'(1);
                    end else begin
                        data_q <= m[PROD_W-1:WORD_W];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pcg32_range_sampler.sv
// Scoreboard bench for pcg32_range_sampler: random bounds and words against an arithmetic model.
module tb_pcg32_range_sampler;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  r;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_bound = '0;
    logic        rnd_valid = 1'b0;
    logic        rnd_ready;
    logic [31:0] rnd_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [7:0]  out_rejects;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    bit          bp_hold = 1'b0;
    exp_t        sb_q[$];
    logic [31:0] rnd_q[$];

    pcg32_range_sampler #(.REJ_CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_bound   (req_bound),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .rnd_data    (rnd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_rejects (out_rejects)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Random word source in front of the DUT; pops only on a real handshake.
    always @(posedge clk) begin
        if (rnd_valid && rnd_ready && rnd_q.size() > 0) void'(rnd_q.pop_front());
        #1;
        if (rst_n && rnd_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            rnd_valid = 1'b1;
            rnd_data  = rnd_q[0];
        end else begin
            rnd_valid = 1'b0;
            rnd_data  = $urandom;
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = !bp_hold && ($urandom_range(0, 3) != 0);
    end

    // Monitor: latency, stability and scoreboard comparison.
    int          req_cyc, rnd_cyc;
    logic [31:0] req_s;
    bit          fetch_pend, out_seen, prev_hold;
    logic [31:0] prev_data;
    logic [7:0]  prev_rej;
    exp_t        e;

    always @(negedge clk) begin
        if (!rst_n) begin
            fetch_pend = 1'b0;
            out_seen   = 1'b0;
            prev_hold  = 1'b0;
        end else begin
            if (fetch_pend && rnd_ready) begin
                check("div_latency", 64'(cyc - req_cyc), (req_s == 0) ? 64'd1 : 64'd33);
                fetch_pend = 1'b0;
            end
            if (req_valid && req_ready) begin
                req_cyc    = cyc;
                req_s      = req_bound;
                fetch_pend = 1'b1;
            end
            if (rnd_valid && rnd_ready) rnd_cyc = cyc;
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(prev_data));
                check("hold_rejects", 64'(out_rejects), 64'(prev_rej));
            end
            if (out_valid) begin
                check("rnd_ready_in_out", 64'(rnd_ready), 64'd0);
                if (!out_seen) begin
                    check("out_latency", 64'(cyc - rnd_cyc), 64'd2);
                    out_seen = 1'b1;
                end
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e.d));
                    check("out_rejects", 64'(out_rejects), 64'(e.r));
                    check("words_consumed", 64'(rnd_q.size()), 64'd0);
                end
                out_seen = 1'b0;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_rej  = out_rejects;
        end
    end

    // Behavioural reference: t = (2^32 - s) mod s, accept when low32(x*s) >= t.
    task automatic model(input logic [31:0] s, output logic [31:0] w[$], output exp_t ex);
        logic [63:0] t, m;
        logic [31:0] x;
        logic [7:0]  rej = 0;
        t = (s == 0) ? 64'd0 : ((64'h1_0000_0000 - {32'd0, s}) % {32'd0, s});
        w.delete();
        forever begin
            x = $urandom;
            w.push_back(x);
            if (s == 0) begin
                ex = '{d: x, r: rej};
                break;
            end
            m = {32'd0, x} * {32'd0, s};
            if ((m % 64'h1_0000_0000) < t) begin
                if (rej != 8'hFF) rej++;
            end else begin
                ex = '{d: 32'(m / 64'h1_0000_0000), r: rej};
                break;
            end
        end
    endtask

    task automatic issue(input logic [31:0] s, input logic [31:0] w[$], input exp_t ex);
        bit ok = 1'b0;
        sb_q.push_back(ex);
        foreach (w[i]) rnd_q.push_back(w[i]);
        req_bound = s;
        req_valid = 1'b1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_bound = $urandom;
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("drain_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
            rnd_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w[$];
        logic [31:0] s;
        logic [31:0] held;
        exp_t        ex;
        bit          seen;

        // Reset with noisy inputs
        repeat (3) begin
            @(posedge clk);
            #1;
            req_valid = $urandom;
            req_bound = $urandom;
        end
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rnd_ready", 64'(rnd_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_rejects", 64'(out_rejects), 64'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed: s=6, t=4
        w = '{32'h8000_0001};
        issue(32'd6, w, '{d: 32'd3, r: 8'd0});
        wait_drain();
        w = '{32'hFFFF_FFFF};
        issue(32'd6, w, '{d: 32'd5, r: 8'd0});
        wait_drain();
        w = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0001};
        issue(32'd6, w, '{d: 32'd3, r: 8'd2});
        wait_drain();
        w = '{32'hDEAD_BEEF};
        issue(32'd0, w, '{d: 32'hDEAD_BEEF, r: 8'd0});
        wait_drain();
        w = '{32'hCAFE_F00D};
        issue(32'd1, w, '{d: 32'd0, r: 8'd0});
        wait_drain();

        // Back-pressure: OUT held for 10 cycles
        bp_hold = 1'b1;
        w = '{32'h8000_0001};
        issue(32'd6, w, '{d: 32'd3, r: 8'd0});
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("bp_out_valid_seen", 64'(seen), 64'd1);
        held = out_data;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_data", 64'(out_data), 64'(held));
            check("bp_rnd_ready", 64'(rnd_ready), 64'd0);
        end
        bp_hold = 1'b0;
        wait_drain();

        // Mid-DIV reset aborts the request
        model(32'd7, w, ex);
        issue(32'd7, w, ex);
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", 64'(req_ready), 64'd1);
        check("abort_rnd_ready", 64'(rnd_ready), 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        check("abort_out_rejects", 64'(out_rejects), 64'd0);
        sb_q.delete();
        rnd_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        w = '{32'h8000_0001};
        issue(32'd6, w, '{d: 32'd3, r: 8'd0});
        wait_drain();

        // Random bounds against the reference model
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0:       s = 32'd0;
                1:       s = 32'd1;
                2:       s = 32'd1 << $urandom_range(0, 31);
                3:       s = $urandom_range(2, 100);
                4:       s = 32'h8000_0000 + $urandom_range(1, 1000);
                default: s = $urandom;
            endcase
            model(s, w, ex);
            issue(s, w, ex);
            wait_drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
